// File: rtl/pcie_rx_pkg.sv
// Shared definitions for the PCIe receive path: aligner FSM states and
// default framing/alignment constants.
package pcie_rx_pkg;

    typedef enum logic [2:0] {
        ST_SEARCH = 3'd0,
        ST_SLIP   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_VERIFY = 3'd3,
        ST_LOCKED = 3'd4
    } align_state_e;

    localparam logic [15:0] SYNC_PATTERN_DEF = 16'hF0F0;
    localparam int          LOCK_COUNT_DEF   = 32'd4;
    localparam int          UNLOCK_COUNT_DEF = 32'd8;
    localparam int          SLIP_WAIT_DEF    = 32'd2;

endpackage

// File: rtl/align_sat_counter.sv
// Saturating event counter with synchronous clear; hit flags the increment
// that brings the count up to LIMIT so the owner can act on the same edge.
module align_sat_counter #(
    parameter int LIMIT = 32'd4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic hit
);

    localparam int            CW       = (LIMIT < 32'd1) ? 32'd1 : $clog2(LIMIT + 32'd1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(LIMIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(LIMIT - 32'd1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins over increment, increment stops at LIMIT.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {CW{1'b0}};
        end else if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // A zero limit can never be reached by an increment.
    assign hit = inc && (count_q == CNT_LAST) && (LIMIT > 32'd0);

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rx_align_ctrl.sv
// Word aligner: hunts for the sync header by pulsing bit_slip to the
// deserializer, qualifies lock over several words and forwards aligned data.
module rx_align_ctrl
    import pcie_rx_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32'd128,
    parameter int                    SYNC_WIDTH   = 32'd16,
    parameter logic [SYNC_WIDTH-1:0] SYNC_PATTERN = SYNC_PATTERN_DEF,
    parameter int                    LOCK_COUNT   = LOCK_COUNT_DEF,
    parameter int                    UNLOCK_COUNT = UNLOCK_COUNT_DEF,
    parameter int                    SLIP_WAIT    = SLIP_WAIT_DEF,
    localparam int                   SW           = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] word_in,
    input  logic                  word_valid,
    output logic                  bit_slip,
    output logic                  locked,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    output logic                  hdr_err,
    output logic                  align_fail,
    output logic [SW-1:0]         slip_cnt
);

    localparam logic [SW-1:0] SLIP_LAST = SW'(DATA_WIDTH - 32'd1);
    localparam logic [SW-1:0] SLIP_ONE  = SW'(32'd1);

    align_state_e          state_q, state_d;
    logic [SW-1:0]         slip_cnt_q, slip_cnt_d;
    logic                  bit_slip_q, bit_slip_d;
    logic                  locked_q, locked_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  dout_vld_q, dout_vld_d;
    logic                  hdr_err_q, hdr_err_d;
    logic                  align_fail_q, align_fail_d;

    logic hdr_ok;
    logic enter_slip;
    logic good_inc, good_clr, good_hit;
    logic bad_inc, bad_clr, bad_hit;
    logic wait_inc, wait_clr, wait_hit;

    assign hdr_ok = (word_in[DATA_WIDTH-1 -: SYNC_WIDTH] == SYNC_PATTERN);

    align_sat_counter #(.LIMIT(LOCK_COUNT)) u_good_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (good_clr),
        .inc   (good_inc),
        .hit   (good_hit)
    );

    align_sat_counter #(.LIMIT(UNLOCK_COUNT)) u_bad_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (bad_clr),
        .inc   (bad_inc),
        .hit   (bad_hit)
    );

    align_sat_counter #(.LIMIT(SLIP_WAIT)) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (wait_clr),
        .inc   (wait_inc),
        .hit   (wait_hit)
    );

    // Alignment FSM, counter control and next values of every registered output.
    always_comb begin
        state_d      = state_q;
        slip_cnt_d   = slip_cnt_q;
        bit_slip_d   = 1'b0;
        hdr_err_d    = 1'b0;
        align_fail_d = 1'b0;
        dout_vld_d   = 1'b0;
        data_out_d   = data_out_q;
        enter_slip   = 1'b0;
        good_inc     = 1'b0;
        good_clr     = 1'b0;
        bad_inc      = 1'b0;
        bad_clr      = 1'b0;
        wait_inc     = 1'b0;
        wait_clr     = 1'b0;

        if (!en) begin
            state_d    = ST_SEARCH;
            slip_cnt_d = {SW{1'b0}};
            good_clr   = 1'b1;
            bad_clr    = 1'b1;
            wait_clr   = 1'b1;
        end else begin
            case (state_q)
                ST_SEARCH: begin
                    if (word_valid && hdr_ok) begin
                        good_inc = 1'b1;
                        if (good_hit) begin
                            good_clr = 1'b1;
                            state_d  = ST_LOCKED;
                        end else begin
                            state_d  = ST_VERIFY;
                        end
                    end else if (word_valid) begin
                        enter_slip = 1'b1;
                    end else begin
                        state_d = ST_SEARCH;
                    end
                end
                ST_SLIP: begin
                    // Words arriving during the slip cycle are ignored outright.
                    if (SLIP_WAIT == 32'd0) begin
                        state_d = ST_SEARCH;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (word_valid) begin
                        wait_inc = 1'b1;
                        if (wait_hit) begin
                            wait_clr = 1'b1;
                            state_d  = ST_SEARCH;
                        end else begin
                            state_d  = ST_WAIT;
                        end
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_VERIFY: begin
                    if (word_valid && hdr_ok) begin
                        good_inc = 1'b1;
                        if (good_hit) begin
                            good_clr = 1'b1;
                            state_d  = ST_LOCKED;
                        end else begin
                            state_d  = ST_VERIFY;
                        end
                    end else if (word_valid) begin
                        good_clr   = 1'b1;
                        enter_slip = 1'b1;
                    end else begin
                        state_d = ST_VERIFY;
                    end
                end
                ST_LOCKED: begin
                    if (word_valid && hdr_ok) begin
                        bad_clr    = 1'b1;
                        dout_vld_d = 1'b1;
                        data_out_d = word_in;
                    end else if (word_valid) begin
                        hdr_err_d = 1'b1;
                        bad_inc   = 1'b1;
                        if (bad_hit) begin
                            // The unlocking word itself is dropped.
                            bad_clr    = 1'b1;
                            slip_cnt_d = {SW{1'b0}};
                            state_d    = ST_SEARCH;
                        end else begin
                            dout_vld_d = 1'b1;
                            data_out_d = word_in;
                        end
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                end
            endcase

            if (enter_slip) begin
                state_d    = ST_SLIP;
                bit_slip_d = 1'b1;
                if (slip_cnt_q == SLIP_LAST) begin
                    slip_cnt_d   = {SW{1'b0}};
                    align_fail_d = 1'b1;
                end else begin
                    slip_cnt_d   = slip_cnt_q + SLIP_ONE;
                end
            end else begin
                bit_slip_d = 1'b0;
            end
        end

        locked_d = (state_d == ST_LOCKED);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_SEARCH;
            slip_cnt_q   <= {SW{1'b0}};
            bit_slip_q   <= 1'b0;
            locked_q     <= 1'b0;
            data_out_q   <= {DATA_WIDTH{1'b0}};
            dout_vld_q   <= 1'b0;
            hdr_err_q    <= 1'b0;
            align_fail_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            slip_cnt_q   <= slip_cnt_d;
            bit_slip_q   <= bit_slip_d;
            locked_q     <= locked_d;
            data_out_q   <= data_out_d;
            dout_vld_q   <= dout_vld_d;
            hdr_err_q    <= hdr_err_d;
            align_fail_q <= align_fail_d;
        end
    end

    assign bit_slip       = bit_slip_q;
    assign locked         = locked_q;
    assign data_out       = data_out_q;
    assign data_out_valid = dout_vld_q;
    assign hdr_err        = hdr_err_q;
    assign align_fail     = align_fail_q;
    assign slip_cnt       = slip_cnt_q;

endmodule

// File: tb/tb_rx_align_ctrl.sv
// Randomised bench for rx_align_ctrl: a bit-accurate deserializer that honours
// bit_slip feeds the DUT, and a behavioural aligner model predicts every output.
module tb_rx_align_ctrl;

    localparam int NFR = 32'd4100;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic [127:0] word_in;
    logic         word_valid;
    logic         bit_slip;
    logic         locked;
    logic [127:0] data_out;
    logic         data_out_valid;
    logic         hdr_err;
    logic         align_fail;
    logic [6:0]   slip_cnt;

    rx_align_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .word_in        (word_in),
        .word_valid     (word_valid),
        .bit_slip       (bit_slip),
        .locked         (locked),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .hdr_err        (hdr_err),
        .align_fail     (align_fail),
        .slip_cnt       (slip_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- serial stream / deserializer ----------------
    logic [127:0] frames [0:NFR-1];
    int           pos;

    task automatic fill_frames(input bit noisy);
        for (int i = 0; i < NFR; i++) begin
            logic [127:0] f;
            int           pct;
            f = {$urandom, $urandom, $urandom, $urandom};
            f[127:112] = 16'hF0F0;
            pct = (((i / 64) % 4) == 3) ? 60 : 4;
            if (noisy && ($urandom_range(0, 99) < pct)) f[127:112] = 16'h0F0F ^ 16'($urandom);
            frames[i] = f;
        end
    endtask

    function automatic logic [127:0] get_word(input int p);
        logic [255:0] two;
        int           idx;
        idx = p / 128;
        two = {frames[idx], frames[idx + 1]};
        two = two << (p % 128);
        return two[255:128];
    endfunction

    // ---------------- behavioural reference model ----------------
    // Phase of the hunt: looking, slipping, discarding, qualifying, aligned.
    localparam int P_LOOK = 0, P_SLIP = 1, P_DISCARD = 2, P_QUAL = 3, P_ALIGNED = 4;
    int           m_phase, m_good, m_bad, m_disc, m_slips;
    bit           m_bs, m_he, m_af, m_dov;
    logic [127:0] m_do;

    task automatic model_reset();
        m_phase = P_LOOK; m_good = 0; m_bad = 0; m_disc = 0; m_slips = 0;
        m_bs = 0; m_he = 0; m_af = 0; m_dov = 0; m_do = '0;
    endtask

    task automatic model_slip();
        m_phase = P_SLIP;
        m_bs    = 1;
        m_good  = 0;
        m_af    = (m_slips == 127);
        m_slips = (m_slips + 1) % 128;
    endtask

    task automatic model_step(input bit e, input bit v, input logic [127:0] w);
        bit good;
        m_bs = 0; m_he = 0; m_af = 0; m_dov = 0;
        good = (w[127:112] == 16'hF0F0);
        if (!e) begin
            m_phase = P_LOOK; m_good = 0; m_bad = 0; m_disc = 0; m_slips = 0;
        end else if (m_phase == P_SLIP) begin
            m_phase = P_DISCARD; m_disc = 0;
        end else if (v) begin
            if (m_phase == P_DISCARD) begin
                m_disc++;
                if (m_disc == 2) m_phase = P_LOOK;
            end else if (m_phase == P_LOOK || m_phase == P_QUAL) begin
                if (good) begin
                    m_good++;
                    m_phase = (m_good == 4) ? P_ALIGNED : P_QUAL;
                    if (m_good == 4) m_good = 0;
                end else begin
                    model_slip();
                end
            end else begin
                if (good) begin
                    m_bad = 0; m_dov = 1; m_do = w;
                end else begin
                    m_he = 1;
                    m_bad++;
                    if (m_bad == 8) begin
                        m_bad = 0; m_slips = 0; m_phase = P_LOOK;
                    end else begin
                        m_dov = 1; m_do = w;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        check_eq("bit_slip", bit_slip, m_bs);
        check_eq("locked", locked, (m_phase == P_ALIGNED));
        check_eq("data_out_valid", data_out_valid, m_dov);
        check_eq("data_out", data_out, m_do);
        check_eq("hdr_err", hdr_err, m_he);
        check_eq("align_fail", align_fail, m_af);
        check_eq("slip_cnt", slip_cnt, m_slips);
    endtask

    int n_bs, n_he, n_af, n_dov;

    task automatic cycle(input bit e, input bit v, input logic [127:0] w);
        en = e; word_valid = v; word_in = w;
        model_step(e, v, w);
        @(posedge clk);
        #1;
        compare_all();
        n_bs  += int'(bit_slip);
        n_he  += int'(hdr_err);
        n_af  += int'(align_fail);
        n_dov += int'(data_out_valid);
    endtask

    task automatic deser_cycle(input bit e, input bit v);
        logic [127:0] w;
        w = v ? get_word(pos) : {$urandom, $urandom, $urandom, $urandom};
        cycle(e, v, w);
        if (v) pos += 128;
        if (bit_slip) pos += 1;
    endtask

    task automatic do_reset();
        reset = 1'b1; en = 1'b0; word_valid = 1'b0; word_in = '0;
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        reset = 1'b0;
        n_bs = 0; n_he = 0; n_af = 0; n_dov = 0;
    endtask

    initial begin
        int first_dov, prev_sc, slips, afs;
        reset = 1'b1; en = 1'b0; word_valid = 1'b0; word_in = '0;

        // Reset state
        do_reset();

        // Aligned stream: lock on 4th word, forwarding from the 5th
        fill_frames(1'b0);
        pos = 0; first_dov = 0;
        for (int i = 1; i <= 8; i++) begin
            deser_cycle(1'b1, 1'b1);
            if (i == 3) check_eq("aligned_not_yet_locked", locked, 1'b0);
            if (i == 4) check_eq("aligned_locked_4th", locked, 1'b1);
            if (data_out_valid && first_dov == 0) first_dov = i;
        end
        check_eq("aligned_first_dov", first_dov, 32'd5);
        check_eq("aligned_no_slip", n_bs, 32'd0);

        // Stream offset by 3 bits
        do_reset();
        pos = 125;
        for (int i = 0; i < 300 && !locked; i++) deser_cycle(1'b1, ($urandom_range(0, 3) != 0));
        check_eq("offset3_locked", locked, 1'b1);
        check_eq("offset3_slips", n_bs, 32'd3);
        check_eq("offset3_slip_cnt", slip_cnt, 7'd3);

        // Lock loss: 7 bad, 1 good, 8 bad
        n_he = 0;
        for (int i = 1; i <= 16; i++) begin
            logic [127:0] w;
            w = {$urandom, $urandom, $urandom, $urandom};
            w[127:112] = (i == 8) ? 16'hF0F0 : 16'h0F0F;
            cycle(1'b1, 1'b1, w);
            if (i == 7)  check_eq("unlock_held_7", locked, 1'b1);
            if (i == 15) check_eq("unlock_held_15", locked, 1'b1);
        end
        check_eq("unlock_dropped", locked, 1'b0);
        check_eq("unlock_hdr_err_cnt", n_he, 32'd15);
        check_eq("unlock_slip_cnt", slip_cnt, 7'd0);

        // All-zero stream: slip counter wraps once
        do_reset();
        slips = 0; afs = 0;
        for (int i = 0; i < 700 && slips < 128; i++) begin
            prev_sc = int'(slip_cnt);
            cycle(1'b1, 1'b1, 128'd0);
            if (bit_slip) slips++;
            if (align_fail) begin
                afs++;
                check_eq("wrap_from", prev_sc, 32'd127);
                check_eq("wrap_to", slip_cnt, 7'd0);
                check_eq("wrap_with_slip", bit_slip, 1'b1);
            end
        end
        check_eq("wrap_slips", slips, 32'd128);
        check_eq("wrap_align_fail_cnt", afs, 32'd1);

        // Reset asserted during SLIP
        do_reset();
        cycle(1'b1, 1'b1, 128'd0);
        check_eq("slip_entered", bit_slip, 1'b1);
        #2 reset = 1'b1;
        #1;
        check_eq("rst_async_bit_slip", bit_slip, 1'b0);
        check_eq("rst_async_slip_cnt", slip_cnt, 7'd0);
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        reset = 1'b0;
        cycle(1'b1, 1'b0, 128'd0);

        // en dropped while locked
        fill_frames(1'b0);
        pos = 0;
        for (int i = 0; i < 6; i++) deser_cycle(1'b1, 1'b1);
        check_eq("en_pre_locked", locked, 1'b1);
        deser_cycle(1'b0, 1'b1);
        check_eq("en_off_locked", locked, 1'b0);
        check_eq("en_off_dov", data_out_valid, 1'b0);

        // Random soak against the model
        do_reset();
        fill_frames(1'b1);
        pos = $urandom_range(0, 127);
        for (int i = 0; i < 3000; i++)
            deser_cycle(($urandom_range(0, 99) < 97), ($urandom_range(0, 99) < 75));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rx_align_ctrl.md
RX_ALIGN_CTRL -- requirements
Module: rx_align_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128: width of the deserialized word.
REQ-002 SHALL have parameter SYNC_WIDTH, default 16: width of the sync header, taken from word_in[DATA_WIDTH-1 -: SYNC_WIDTH].
REQ-003 SHALL have parameter SYNC_PATTERN, default 16'hF0F0: expected header value.
REQ-004 SHALL have parameter LOCK_COUNT, default 4: consecutive good headers needed to lock.
REQ-005 SHALL have parameter UNLOCK_COUNT, default 8: consecutive bad headers needed to drop lock.
REQ-006 SHALL have parameter SLIP_WAIT, default 2: valid words discarded after each slip.
REQ-007 SHALL have port clk, input, 1: clock; all logic on its rising edge.
REQ-008 SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-009 SHALL have port en, input, 1: alignment enable.
REQ-010 SHALL have port word_in, input, DATA_WIDTH: word from the deserializer.
REQ-011 SHALL have port word_valid, input, 1: word_in is valid this cycle.
REQ-012 SHALL have port bit_slip, output, 1: one-cycle pulse telling the deserializer to drop one serial bit.
REQ-013 SHALL have port locked, output, 1: alignment achieved.
REQ-014 SHALL have port data_out, output, DATA_WIDTH: aligned word.
REQ-015 SHALL have port data_out_valid, output, 1: data_out is valid.
REQ-016 SHALL have port hdr_err, output, 1: one-cycle pulse on a bad header while in LOCKED.
REQ-017 SHALL have port align_fail, output, 1: one-cycle pulse when slip_cnt wraps.
REQ-018 SHALL have port slip_cnt, output, $clog2(DATA_WIDTH): slips issued since the last SEARCH entry from reset, unlock or en=0.

Function
REQ-019 SHALL implement an FSM with states SEARCH, SLIP, WAIT, VERIFY and LOCKED.
REQ-020 SEARCH: on word_valid, a header equal to SYNC_PATTERN SHALL go to VERIFY with good_cnt=1; any other header SHALL go to SLIP.
REQ-021 SLIP SHALL last exactly one cycle, assert bit_slip, increment slip_cnt, then go to WAIT.
REQ-022 slip_cnt at DATA_WIDTH-1 SHALL wrap to 0 on the next slip and pulse align_fail in the same cycle as bit_slip.
REQ-023 A word_valid arriving while in SLIP SHALL be ignored and SHALL NOT count toward SLIP_WAIT.
REQ-024 WAIT SHALL discard SLIP_WAIT valid words, then go to SEARCH; the next valid word is evaluated in SEARCH.
REQ-025 VERIFY, per valid word: a good header SHALL increment good_cnt; good_cnt reaching LOCK_COUNT SHALL go to LOCKED; a bad header SHALL go to SLIP and clear good_cnt.
REQ-026 LOCKED SHALL hold locked=1.
REQ-027 LOCKED, bad header: SHALL pulse hdr_err and increment bad_cnt.
REQ-028 LOCKED, good header: SHALL clear bad_cnt.
REQ-029 bad_cnt reaching UNLOCK_COUNT SHALL go to SEARCH, clear slip_cnt and drop locked on the same edge.
REQ-030 In LOCKED, each valid word, good or bad, SHALL produce data_out=word_in with data_out_valid=1 exactly one cycle later (latency 1).
REQ-031 The word that causes unlock SHALL NOT be forwarded.
REQ-032 data_out_valid SHALL be 0 in every state other than LOCKED.
REQ-033 data_out SHALL hold its last value when data_out_valid=0.
REQ-034 The word completing LOCK_COUNT SHALL NOT be forwarded; forwarding starts with the next valid word.
REQ-035 en=0 SHALL force SEARCH on the next edge, clear all counters, and suppress bit_slip, hdr_err and data_out_valid; en has priority over all other transitions.
REQ-036 Outputs SHALL be registered, with no combinational path from word_in to any output.
REQ-037 Counter widths SHALL be $clog2(max+1) of their limit.
REQ-038 Comparisons SHALL be exact equality.

Reset
REQ-039 Reset SHALL put the FSM in SEARCH.
REQ-040 Reset SHALL clear good_cnt, bad_cnt, wait_cnt and slip_cnt.
REQ-041 Reset SHALL drive bit_slip, locked, data_out_valid, hdr_err and align_fail to 0, and data_out to all-zero.
REQ-042 Reset asserted mid-operation, including during SLIP, SHALL abort immediately with no trailing bit_slip or data_out_valid.

Structure
REQ-043 The FSM state enum and the SYNC_PATTERN/LOCK_COUNT/UNLOCK_COUNT/SLIP_WAIT defaults SHALL live in shared package pcie_rx_pkg.
REQ-044 A single sub-module, align_sat_counter (parameterised limit, inc/clr, hit flag), SHALL be used for good_cnt, bad_cnt and wait_cnt.

Verification
REQ-045 Aligned stream of F0F0-headed words, en=1 -> no bit_slip, locked=1 after the 4th valid word, first data_out_valid on the cycle after the 5th valid word.
REQ-046 Stream offset by 3 bits (deserializer model honours bit_slip) -> exactly 3 bit_slip pulses, slip_cnt=3, then lock.
REQ-047 Locked; inject 7 bad headers, 1 good, then 8 bad -> 15 hdr_err pulses, lock held through the first 7, locked drops on the 8th of the final run, slip_cnt=0.
REQ-048 All-zero stream for 128 slips -> align_fail pulses once, with slip_cnt wrapping 127->0.
REQ-049 Assert reset during SLIP, and separately drop en while LOCKED -> next cycle all outputs 0, FSM in SEARCH.
